regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Parameterised register file with byte-enabled writes, optional write-to-read bypass,
// a debug/LCD mirror and a valid/ready register dump stream.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int LCD_IDX  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output logic [DATA_W-1:0]   lcd_data,
    input  logic                dump_start,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [ADDR_W-1:0]   dump_idx,
    output logic [DATA_W-1:0]   dump_data,
    output logic                dump_busy,
    output logic                dump_done,
    output logic [1:0]          dump_state
);

    localparam int NREGS  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LCD_A = ADDR_W'(LCD_IDX);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

    function automatic logic hardwired(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_merged;
    logic              wr_fire;

    // Writes are suppressed during reset and for the hardwired zero register.
    assign wr_fire = wr_en && !reset && !hardwired(wr_addr);

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < NBYTES; b++) begin
            wr_mask[b*8 +: 8] = {8{wr_be[b]}};
        end
    end

    assign wr_merged = (regs[wr_addr] & ~wr_mask) | (wr_data & wr_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;
    logic              byp1;
    logic              byp2;

    assign raw1 = hardwired(rd_addr1) ? '0 : regs[rd_addr1];
    assign raw2 = hardwired(rd_addr2) ? '0 : regs[rd_addr2];
    assign byp1 = (BYPASS != 0) && wr_fire && (wr_addr == rd_addr1);
    assign byp2 = (BYPASS != 0) && wr_fire && (wr_addr == rd_addr2);

    assign rd_data1 = byp1 ? ((raw1 & ~wr_mask) | (wr_data & wr_mask)) : raw1;
    assign rd_data2 = byp2 ? ((raw2 & ~wr_mask) | (wr_data & wr_mask)) : raw2;
    assign dbg_data = hardwired(dbg_addr) ? '0 : regs[dbg_addr];
    assign lcd_data = hardwired(LCD_A) ? '0 : regs[LCD_A];

    // Dump stream: dump_valid asserted means dump_idx/dump_data are offered;
    // a transfer happens on a rising edge where both dump_valid and dump_ready are 1.
    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dump_start) begin
                        state   <= ST_SEND;
                        idx     <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        if (idx == LAST) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    idx    <= '0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    idx     <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Dump data reads stored contents, so a coinciding write shows its old value.
    assign dump_data  = (valid_q && !hardwired(idx)) ? regs[idx] : '0;
    assign dump_valid = valid_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;
    assign dump_idx   = idx;
    assign dump_state = state;

endmodule
